// File: rtl/button_nav_sm.sv
// Button front end for the snake game: per-button synchroniser, debouncer and press-pulse
// generator, followed by the direction state machine gated by the master game state.
module button_nav_sm #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       BTNR,
  input  logic [1:0] MASTER_STATE,
  output logic       BTNU_PULSE,
  output logic       BTND_PULSE,
  output logic       BTNL_PULSE,
  output logic       BTNR_PULSE,
  output logic [1:0] DIRECTION,
  output logic       DIR_CHANGED
);

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  localparam logic [1:0] MS_IDLE = 2'b00;
  localparam logic [1:0] MS_PLAY = 2'b01;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Bit order everywhere: 0 = up, 1 = down, 2 = left, 3 = right.
  logic [3:0] raw;
  logic [3:0] pulse;

  assign raw = {BTNR, BTNL, BTND, BTNU};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic                 sync1_reg;
      logic                 sync2_reg;
      logic                 stable_reg;
      logic                 stable_d_reg;
      logic                 pulse_reg;
      logic [CNT_WIDTH-1:0] cnt_reg;

      always_ff @(posedge CLK) begin
        if (RESET) begin
          sync1_reg    <= 1'b0;
          sync2_reg    <= 1'b0;
          stable_reg   <= 1'b0;
          stable_d_reg <= 1'b0;
          pulse_reg    <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          sync1_reg    <= raw[gi];
          sync2_reg    <= sync1_reg;
          stable_d_reg <= stable_reg;
          pulse_reg    <= stable_reg & ~stable_d_reg;
          // Any sample agreeing with the stable level restarts the qualification window.
          if (sync2_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= sync2_reg;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
          end
        end
      end

      assign pulse[gi] = pulse_reg;
    end
  endgenerate

  assign BTNU_PULSE = pulse[0];
  assign BTND_PULSE = pulse[1];
  assign BTNL_PULSE = pulse[2];
  assign BTNR_PULSE = pulse[3];

  dir_t dir_reg;
  logic dir_changed_reg;
  logic turn_valid;
  dir_t turn_dir;

  // Only perpendicular headings are legal turns, so a vertical heading can only take L/R
  // and a horizontal one only U/D; within each pair the U>D>L>R priority still applies.
  always_comb begin
    turn_valid = 1'b0;
    turn_dir   = dir_reg;
    if (!dir_reg[0]) begin
      if (pulse[2]) begin
        turn_valid = 1'b1;
        turn_dir   = DIR_LEFT;
      end else if (pulse[3]) begin
        turn_valid = 1'b1;
        turn_dir   = DIR_RIGHT;
      end
    end else begin
      if (pulse[0]) begin
        turn_valid = 1'b1;
        turn_dir   = DIR_UP;
      end else if (pulse[1]) begin
        turn_valid = 1'b1;
        turn_dir   = DIR_DOWN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dir_reg         <= DIR_RIGHT;
      dir_changed_reg <= 1'b0;
    end else begin
      dir_changed_reg <= 1'b0;
      case (MASTER_STATE)
        MS_IDLE: dir_reg <= DIR_RIGHT;
        MS_PLAY: begin
          if (turn_valid) begin
            dir_reg         <= turn_dir;
            dir_changed_reg <= 1'b1;
          end
        end
        default: dir_reg <= dir_reg;
      endcase
    end
  end

  assign DIRECTION   = dir_reg;
  assign DIR_CHANGED = dir_changed_reg;

endmodule

// File: tb/tb_button_nav_sm.sv
// Bench for button_nav_sm: directed scenarios plus random button/state activity, all
// checked every cycle against a window-based reference model.
module tb_button_nav_sm;

  localparam int N    = 4;
  localparam int CW   = 3;
  localparam bit [31:0] MASK = (32'd1 << N) - 32'd1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0;      // 0 = U, 1 = D, 2 = L, 3 = R
  logic [1:0] ms  = 2'b00;
  logic       pu, pd, pl, pr;
  logic [1:0] direction;
  logic       dir_changed;

  button_nav_sm #(.DEBOUNCE_CYCLES(N), .CNT_WIDTH(CW)) dut (
    .CLK(clk), .RESET(rst),
    .BTNU(btn[0]), .BTND(btn[1]), .BTNL(btn[2]), .BTNR(btn[3]),
    .MASTER_STATE(ms),
    .BTNU_PULSE(pu), .BTND_PULSE(pd), .BTNL_PULSE(pl), .BTNR_PULSE(pr),
    .DIRECTION(direction), .DIR_CHANGED(dir_changed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a button's level is accepted once the last N synchronised samples
  // taken since the previous acceptance all disagree with the accepted level.
  logic [1:0] heading [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  bit [3:0]  m_s1, m_s2, m_stable, m_rose, m_pulse;
  bit [31:0] hist [4];
  int        age [4];
  bit [1:0]  m_dir = 2'b01;
  bit        m_dchg;
  logic [3:0] obs_p;

  task automatic model_edge();
    bit [1:0] nd;
    bit       nc;
    bit [1:0] c;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_rose = 0; m_pulse = 0;
      m_dir = 2'b01; m_dchg = 0;
      for (int b = 0; b < 4; b++) begin hist[b] = 0; age[b] = 0; end
    end else begin
      nd = m_dir;
      nc = 0;
      if (ms == 2'b00) nd = 2'b01;
      else if (ms == 2'b01) begin
        for (int k = 0; k < 4; k++) begin
          c = heading[k];
          // Legal turn = neither same heading nor its reverse, i.e. perpendicular.
          if (m_pulse[k] && !nc && (c[0] != m_dir[0])) begin
            nd = c;
            nc = 1;
          end
        end
      end
      m_pulse = m_rose;
      for (int b = 0; b < 4; b++) begin
        hist[b] = {hist[b][30:0], m_s2[b]};
        age[b]++;
        m_rose[b] = 0;
        if (age[b] >= N && (hist[b] & MASK) == (m_stable[b] ? 32'd0 : MASK)) begin
          m_stable[b] = ~m_stable[b];
          m_rose[b]   = m_stable[b];
          age[b]      = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
      m_dir = nd;
      m_dchg = nc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    obs_p = {pr, pl, pd, pu};
    check("pulses", 8'(obs_p), 8'(m_pulse));
    check("direction", 8'(direction), 8'(m_dir));
    check("dir_changed", 8'(dir_changed), 8'(m_dchg));
  endtask

  // Hold the masked buttons for `hold` cycles, release and let the release settle.
  task automatic press(input logic [3:0] mask, input int hold, output int np, output int nc);
    np = 0;
    nc = 0;
    btn = btn | mask;
    for (int i = 0; i < hold + 10; i++) begin
      if (i == hold) btn = btn & ~mask;
      step();
      if ((obs_p & mask) != 0) np++;
      if (dir_changed) nc++;
    end
  endtask

  int np, nc, first_edge;
  logic [4:0] bounce;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("reset_dir", 8'(direction), 8'h01);
    check("reset_outs", 8'({obs_p, dir_changed}), 8'h00);
    rst = 1'b0;
    step(); step();

    // 1: BTNU held from edge 1 in IDLE
    btn[0] = 1'b1;
    np = 0; first_edge = 0;
    for (int e = 1; e <= 14; e++) begin
      step();
      if (pu) begin np++; if (first_edge == 0) first_edge = e; end
    end
    check("t1_pulse_edge", 8'(first_edge), 8'd7);
    check("t1_pulse_count", 8'(np), 8'd1);
    check("t1_dir_idle", 8'(direction), 8'h01);
    btn[0] = 1'b0;
    for (int i = 0; i < 8; i++) step();
    $display("test1 BTNU latency: first pulse after edge %0d", first_edge);

    // 2: BTNL bounce, then a clean 6-cycle hold
    bounce = 5'b01101;   // applied LSB first: 1,0,1,1,0
    np = 0;
    for (int i = 0; i < 13; i++) begin
      btn[2] = (i < 5) ? bounce[i] : 1'b0;
      step();
      if (pl) np++;
    end
    check("t2_bounce_pulses", 8'(np), 8'd0);
    press(4'b0100, 6, np, nc);
    check("t2_hold_pulses", 8'(np), 8'd1);
    $display("test2 BTNL bounce rejected, held press pulses %0d", np);

    // 3: PLAY, RIGHT: L is a reversal, U turns
    ms = 2'b01;
    step();
    press(4'b0100, 6, np, nc);
    check("t3_left_dir", 8'(direction), 8'h01);
    check("t3_left_changes", 8'(nc), 8'd0);
    press(4'b0001, 6, np, nc);
    check("t3_up_dir", 8'(direction), 8'h00);
    check("t3_up_changes", 8'(nc), 8'd1);
    $display("test3 PLAY turns: heading %0d", direction);

    // 4: UP, D and R pulse together -> R wins
    press(4'b1010, 6, np, nc);
    check("t4_dir", 8'(direction), 8'h01);
    check("t4_changes", 8'(nc), 8'd1);
    $display("test4 simultaneous D+R: heading %0d", direction);

    // 5: turn UP, go WIN, L ignored, IDLE forces RIGHT
    press(4'b0001, 6, np, nc);
    ms = 2'b10;
    press(4'b0100, 6, np, nc);
    check("t5_win_dir", 8'(direction), 8'h00);
    check("t5_win_changes", 8'(nc), 8'd0);
    ms = 2'b00;
    step();
    check("t5_idle_dir", 8'(direction), 8'h01);
    $display("test5 WIN hold then IDLE: heading %0d", direction);

    // 6: reset mid-debounce with BTNR held through release
    btn[3] = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step(); step();
    check("t6_reset_outs", 8'({obs_p, dir_changed}), 8'h00);
    check("t6_reset_dir", 8'(direction), 8'h01);
    rst = 1'b0;
    np = 0; first_edge = 0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (pr) begin np++; if (first_edge == 0) first_edge = e; end
    end
    check("t6_pulse_edge", 8'(first_edge), 8'd7);
    check("t6_pulse_count", 8'(np), 8'd1);
    btn[3] = 1'b0;
    for (int i = 0; i < 8; i++) step();
    $display("test6 reset mid-debounce: pulse after edge %0d", first_edge);

    // Random phase: bouncy buttons, changing game state, occasional resets
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(7) == 0) btn[b] = ~btn[b];
      if ($urandom_range(39) == 0) ms = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b01;
      rst = ($urandom_range(599) == 0);
      step();
    end
    rst = 1'b0;
    $display("random phase done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
